// File: rtl/gp_dma_pkg.sv
// Shared types and helpers for the general-purpose DMA transfer engine.
package gp_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] AMODE_INC = 2'd0;
  localparam logic [1:0] AMODE_FIX = 2'd1;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

  function automatic logic [4:0] burst_len(input logic [1:0] mode);
    case (mode)
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Words for the next read burst: the burst length, clipped to what is left.
  function automatic logic [4:0] burst_words(input logic [17:0] bc, input logic [1:0] mode);
    logic [18:0] words;
    logic [4:0]  len;
    words = ({1'b0, bc} + 19'd3) >> 2;
    len   = burst_len(mode);
    return (words < {14'd0, len}) ? words[4:0] : len;
  endfunction

  // Modes 2 and 3 are treated as increment.
  function automatic logic addr_steps(input logic [1:0] mode);
    case (mode)
      AMODE_FIX: return 1'b0;
      AMODE_INC: return 1'b1;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/gp_dma_buf.sv
// Staging FIFO between the read and write phases of a DMA burst.
module gp_dma_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH[AW:0]);

  // Read and write phases are exclusive, so the engine never pushes and pops together.
  assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/gp_dma_ctrl.sv
// DMA transfer engine: reads a burst into the staging buffer, then writes it out.
// state   | meaning
// IDLE    | waiting for dma_pending with a nonzero byte count
// RD      | issuing reads, filling the buffer
// WR      | draining the buffer to the destination
// DONE    | one-cycle dma_done after the last write
// ERR     | bus error seen: pulse dma_done, flush buffer
module gp_dma_ctrl
  import gp_dma_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int BUF_AW    = 4
) (
  input  logic        cbus_clk,
  input  logic        cbus_rst,
  input  logic [31:0] source_address,
  input  logic [1:0]  source_amode,
  input  logic [31:0] dest_address,
  input  logic [1:0]  dest_amode,
  input  logic [1:0]  burst_mode,
  input  logic [17:0] byte_count,
  input  logic        dma_pending,
  output logic        active,
  output logic        dma_done,
  output logic        inc_source_address,
  output logic        inc_dest_address,
  output logic        dec_byte_count,
  output logic [31:0] address_p4,
  output logic [17:0] byte_count_m1,
  output logic        dma_error,
  output logic        master_cbus_req,
  output logic        master_cbus_cmd,
  output logic [31:0] master_cbus_address,
  output logic [31:0] master_cbus_wdata,
  output logic [3:0]  master_cbus_byten,
  input  logic        master_cbus_ack,
  input  logic [31:0] master_cbus_rdata,
  input  logic        master_cbus_aerror
);

  state_t          state;
  logic [4:0]      rd_left;
  logic            bus_phase;
  logic            good_ack;
  logic            err_ack;
  logic            rd_ack;
  logic            wr_ack;
  logic            last_pop;
  logic            buf_flush;
  logic            buf_empty;
  logic            buf_full;
  logic [BUF_AW:0] buf_count;
  logic [31:0]     buf_head;

  assign bus_phase = (state == ST_RD) || (state == ST_WR);
  assign good_ack  = bus_phase && master_cbus_ack && !master_cbus_aerror && !cbus_rst;
  assign err_ack   = bus_phase && master_cbus_ack && master_cbus_aerror;
  assign rd_ack    = good_ack && (state == ST_RD);
  assign wr_ack    = good_ack && (state == ST_WR);
  assign last_pop  = wr_ack && (buf_count == (BUF_AW+1)'(1));
  assign buf_flush = (state == ST_ERR);

  gp_dma_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_buf (
    .clk   (cbus_clk),
    .rst   (cbus_rst),
    .flush (buf_flush),
    .push  (rd_ack),
    .pop   (wr_ack),
    .wdata (master_cbus_rdata),
    .rdata (buf_head),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  always_ff @(posedge cbus_clk) begin
    if (cbus_rst) begin
      state     <= ST_IDLE;
      rd_left   <= '0;
      dma_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma_pending && (byte_count != '0)) begin
            dma_error <= 1'b0;
            rd_left   <= burst_words(byte_count, burst_mode);
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          if (err_ack) begin
            dma_error <= 1'b1;
            state     <= ST_ERR;
          end else if (rd_ack) begin
            rd_left <= rd_left - 1'b1;
            if (rd_left == 5'd1) state <= ST_WR;
          end
        end
        ST_WR: begin
          if (err_ack) begin
            dma_error <= 1'b1;
            state     <= ST_ERR;
          end else if (last_pop) begin
            // byte_count is updated at this same edge, so size the next burst from byte_count_m1.
            if (byte_count_m1 == '0) begin
              state <= ST_DONE;
            end else if (dma_pending) begin
              rd_left <= burst_words(byte_count_m1, burst_mode);
              state   <= ST_RD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign active   = (state != ST_IDLE);
  assign dma_done = (state == ST_DONE) || (state == ST_ERR);

  assign master_cbus_req     = bus_phase && !cbus_rst;
  assign master_cbus_cmd     = (state == ST_RD) ? CMD_RD : CMD_WR;
  assign master_cbus_address = (state == ST_RD) ? source_address : dest_address;
  assign master_cbus_wdata   = buf_head;

  always_comb begin
    master_cbus_byten = 4'hF;
    if ((state == ST_WR) && (byte_count < 18'd4)) begin
      case (byte_count[1:0])
        2'd3:    master_cbus_byten = 4'h7;
        2'd2:    master_cbus_byten = 4'h3;
        2'd1:    master_cbus_byten = 4'h1;
        default: master_cbus_byten = 4'hF;
      endcase
    end
  end

  assign inc_source_address = rd_ack && addr_steps(source_amode);
  assign inc_dest_address   = wr_ack && addr_steps(dest_amode);
  assign dec_byte_count     = wr_ack;
  assign address_p4         = master_cbus_address + 32'd4;
  assign byte_count_m1      = (byte_count >= 18'd4) ? (byte_count - 18'd4) : '0;

  assert property (@(posedge cbus_clk) disable iff (cbus_rst) !(rd_ack && buf_full));
  assert property (@(posedge cbus_clk) disable iff (cbus_rst) !((state == ST_WR) && buf_empty));

endmodule

// File: tb/tb_gp_dma_ctrl.sv
// Bench for gp_dma_ctrl: register-block and bus-slave models plus a transfer-level reference.
module tb_gp_dma_ctrl;

  logic        cbus_clk = 1'b0;
  logic        cbus_rst = 1'b1;
  logic [31:0] source_address = '0;
  logic [31:0] dest_address = '0;
  logic [1:0]  source_amode = '0;
  logic [1:0]  dest_amode = '0;
  logic [1:0]  burst_mode = '0;
  logic [17:0] byte_count = '0;
  logic        dma_pending = 1'b0;
  logic        active, dma_done, inc_source_address, inc_dest_address, dec_byte_count;
  logic [31:0] address_p4;
  logic [17:0] byte_count_m1;
  logic        dma_error;
  logic        master_cbus_req, master_cbus_cmd;
  logic [31:0] master_cbus_address, master_cbus_wdata, master_cbus_rdata;
  logic [3:0]  master_cbus_byten;
  logic        master_cbus_ack, master_cbus_aerror;

  gp_dma_ctrl dut (
    .cbus_clk            (cbus_clk),
    .cbus_rst            (cbus_rst),
    .source_address      (source_address),
    .source_amode        (source_amode),
    .dest_address        (dest_address),
    .dest_amode          (dest_amode),
    .burst_mode          (burst_mode),
    .byte_count          (byte_count),
    .dma_pending         (dma_pending),
    .active              (active),
    .dma_done            (dma_done),
    .inc_source_address  (inc_source_address),
    .inc_dest_address    (inc_dest_address),
    .dec_byte_count      (dec_byte_count),
    .address_p4          (address_p4),
    .byte_count_m1       (byte_count_m1),
    .dma_error           (dma_error),
    .master_cbus_req     (master_cbus_req),
    .master_cbus_cmd     (master_cbus_cmd),
    .master_cbus_address (master_cbus_address),
    .master_cbus_wdata   (master_cbus_wdata),
    .master_cbus_byten   (master_cbus_byten),
    .master_cbus_ack     (master_cbus_ack),
    .master_cbus_rdata   (master_cbus_rdata),
    .master_cbus_aerror  (master_cbus_aerror)
  );

  always #5 cbus_clk = ~cbus_clk;

  // Register-block model: loads config, applies the engine's update strobes.
  logic        cfg_load = 1'b0, pend_set = 1'b0, pend_clr = 1'b0;
  logic [31:0] cfg_src = '0, cfg_dst = '0;
  logic [17:0] cfg_bc = '0;

  always @(posedge cbus_clk) begin
    if (cfg_load) begin
      source_address <= cfg_src;
      dest_address   <= cfg_dst;
      byte_count     <= cfg_bc;
    end else begin
      if (inc_source_address) source_address <= address_p4;
      if (inc_dest_address)   dest_address   <= address_p4;
      if (dec_byte_count)     byte_count     <= byte_count_m1;
    end
    if (cbus_rst || dma_done || pend_clr) dma_pending <= 1'b0;
    else if (pend_set)                    dma_pending <= 1'b1;
  end

  // Bus slave: random ready, data is a fixed function of address, optional error on a chosen read.
  int unsigned ack_pct = 100;
  logic        ready = 1'b0;
  logic [31:0] rd_acks = '0;
  logic [31:0] err_at = '0;
  logic        err_en = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) * 32'h0001_0003 + 32'h0BAD_F00D;
  endfunction

  always @(posedge cbus_clk) begin
    ready <= ($urandom_range(0, 99) < ack_pct);
    if (master_cbus_req && master_cbus_ack && master_cbus_cmd) rd_acks <= rd_acks + 1;
  end

  assign master_cbus_ack    = master_cbus_req & ready;
  assign master_cbus_rdata  = mem_data(master_cbus_address);
  assign master_cbus_aerror = master_cbus_ack & master_cbus_cmd & err_en & (rd_acks == err_at);

  // Monitor
  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [3:0]  byten;
    logic [31:0] wdata;
  } txn_t;

  txn_t        obs[$];
  logic [17:0] m1_q[$];
  int          n_inc_src = 0, n_inc_dst = 0, n_both = 0, n_done = 0;
  int          cyc = 0, last_wr_cyc = 0, done_cyc = 0;

  always @(negedge cbus_clk) begin
    cyc = cyc + 1;
    if (master_cbus_req && master_cbus_ack && !master_cbus_aerror) begin
      obs.push_back('{master_cbus_cmd, master_cbus_address, master_cbus_byten, master_cbus_wdata});
      if (!master_cbus_cmd) last_wr_cyc = cyc;
    end
    if (dec_byte_count) m1_q.push_back(byte_count_m1);
    if (inc_source_address) n_inc_src = n_inc_src + 1;
    if (inc_dest_address) n_inc_dst = n_inc_dst + 1;
    if (inc_source_address && inc_dest_address) n_both = n_both + 1;
    if (dma_done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
  end

  // Reference model: the whole transfer as a list of bus transactions.
  txn_t        exp_q[$];
  logic [17:0] expm1_q[$];
  logic [31:0] exp_src, exp_dst;
  int          exp_bc, exp_reads, exp_writes;
  bit          exp_done;

  task automatic build_model(input logic [31:0] s0, input logic [31:0] d0, input logic [1:0] sm,
                             input logic [1:0] dm, input logic [1:0] bm, input int bc, input int max_bursts);
    int          rem, blen, words, nb;
    logic [31:0] s, d;
    logic [31:0] dq[$];
    logic [3:0]  be;
    exp_q.delete();
    expm1_q.delete();
    exp_reads = 0;
    exp_writes = 0;
    blen = (bm == 0) ? 1 : (bm == 1) ? 4 : (bm == 2) ? 8 : 16;
    rem = bc;
    s = s0;
    d = d0;
    nb = 0;
    while (rem > 0 && (max_bursts == 0 || nb < max_bursts)) begin
      words = ((rem + 3) / 4 < blen) ? (rem + 3) / 4 : blen;
      dq.delete();
      for (int i = 0; i < words; i++) begin
        exp_q.push_back('{1'b1, s, 4'hF, 32'h0});
        dq.push_back(mem_data(s));
        exp_reads++;
        if (sm != 2'd1) s = s + 32'd4;
      end
      for (int i = 0; i < words; i++) begin
        be = (rem >= 4) ? 4'hF : (rem == 3) ? 4'h7 : (rem == 2) ? 4'h3 : 4'h1;
        exp_q.push_back('{1'b0, d, be, dq[i]});
        rem = (rem >= 4) ? rem - 4 : 0;
        expm1_q.push_back(18'(rem));
        exp_writes++;
        if (dm != 2'd1) d = d + 32'd4;
      end
      nb++;
    end
    exp_src = s;
    exp_dst = d;
    exp_bc = rem;
    exp_done = (rem == 0);
  endtask

  int tests = 0;
  int errors = 0;

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [1:0] sm,
                           input logic [1:0] dm, input logic [1:0] bm, input int bc);
    @(negedge cbus_clk);
    cfg_src = s;
    cfg_dst = d;
    cfg_bc = 18'(bc);
    source_amode = sm;
    dest_amode = dm;
    burst_mode = bm;
    cfg_load = 1'b1;
    pend_set = 1'b1;
    @(negedge cbus_clk);
    cfg_load = 1'b0;
    pend_set = 1'b0;
  endtask

  task automatic test_reset();
    cbus_rst = 1'b1;
    cfg_load = 1'b1;
    repeat (3) @(negedge cbus_clk);
    cfg_load = 1'b0;
    tests++;
    if (master_cbus_req !== 1'b0) begin errors++; $display("FAIL reset_req_in_rst got %b exp 0", master_cbus_req); end
    cbus_rst = 1'b0;
    @(negedge cbus_clk);
    tests++;
    if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active); end
    tests++;
    if (dma_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", dma_done); end
    tests++;
    if (dma_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", dma_error); end
    tests++;
    if (master_cbus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", master_cbus_req); end
    tests++;
    if ({inc_source_address, inc_dest_address, dec_byte_count} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000", {inc_source_address, inc_dest_address, dec_byte_count});
    end
  endtask

  task automatic test_transfer(input string name, input logic [31:0] s, input logic [31:0] d,
                               input logic [1:0] sm, input logic [1:0] dm, input logic [1:0] bm,
                               input int bc, input int unsigned pct, input bit drop, input bit lat);
    int   o0, m0, src0, dst0, done0, n_obs, n_m1, to;
    txn_t t, e;
    o0 = obs.size();
    m0 = m1_q.size();
    src0 = n_inc_src;
    dst0 = n_inc_dst;
    done0 = n_done;
    build_model(s, d, sm, dm, bm, bc, drop ? 1 : 0);
    ack_pct = pct;
    start_job(s, d, sm, dm, bm, bc);
    if (lat) begin
      tests++;
      if (master_cbus_req !== 1'b0) begin errors++; $display("FAIL %s decision_cycle_req got %b exp 0", name, master_cbus_req); end
    end
    @(negedge cbus_clk);
    if (lat) begin
      tests++;
      if (master_cbus_req !== 1'b1 || master_cbus_cmd !== 1'b1 || master_cbus_address !== s) begin
        errors++;
        $display("FAIL %s first_read got req=%b cmd=%b a=%h exp req=1 cmd=1 a=%h",
                 name, master_cbus_req, master_cbus_cmd, master_cbus_address, s);
      end
    end
    if (drop) pend_clr = 1'b1;
    to = 0;
    while (active && to < 4000) begin
      @(negedge cbus_clk);
      pend_clr = 1'b0;
      to++;
    end
    pend_clr = 1'b0;
    tests++;
    if (active !== 1'b0) begin errors++; $display("FAIL %s timeout active=%b exp 0", name, active); end
    n_obs = obs.size() - o0;
    n_m1 = m1_q.size() - m0;
    tests++;
    if (n_obs !== exp_q.size()) begin errors++; $display("FAIL %s txn_count got %0d exp %0d", name, n_obs, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      t = obs[o0 + i];
      e = exp_q[i];
      tests++;
      if (t.cmd !== e.cmd || t.addr !== e.addr || t.byten !== e.byten || (!e.cmd && t.wdata !== e.wdata)) begin
        errors++;
        $display("FAIL %s txn%0d got cmd=%b a=%h be=%h d=%h exp cmd=%b a=%h be=%h d=%h",
                 name, i, t.cmd, t.addr, t.byten, t.wdata, e.cmd, e.addr, e.byten, e.wdata);
      end
    end
    tests++;
    if (n_m1 !== expm1_q.size()) begin errors++; $display("FAIL %s dec_count got %0d exp %0d", name, n_m1, expm1_q.size()); end
    for (int i = 0; i < expm1_q.size() && i < n_m1; i++) begin
      tests++;
      if (m1_q[m0 + i] !== expm1_q[i]) begin
        errors++;
        $display("FAIL %s byte_count_m1[%0d] got %0d exp %0d", name, i, m1_q[m0 + i], expm1_q[i]);
      end
    end
    tests++;
    if (n_done - done0 !== (exp_done ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_pulses got %0d exp %0d", name, n_done - done0, exp_done ? 1 : 0);
    end
    if (exp_done) begin
      tests++;
      if (done_cyc - last_wr_cyc !== 1) begin
        errors++;
        $display("FAIL %s done_latency got %0d exp 1", name, done_cyc - last_wr_cyc);
      end
    end
    tests++;
    if (n_inc_src - src0 !== ((sm != 2'd1) ? exp_reads : 0)) begin
      errors++;
      $display("FAIL %s inc_src_count got %0d exp %0d", name, n_inc_src - src0, (sm != 2'd1) ? exp_reads : 0);
    end
    tests++;
    if (n_inc_dst - dst0 !== ((dm != 2'd1) ? exp_writes : 0)) begin
      errors++;
      $display("FAIL %s inc_dst_count got %0d exp %0d", name, n_inc_dst - dst0, (dm != 2'd1) ? exp_writes : 0);
    end
    tests++;
    if (n_both !== 0) begin errors++; $display("FAIL %s both_inc got %0d exp 0", name, n_both); end
    tests++;
    if (source_address !== exp_src || dest_address !== exp_dst || byte_count !== 18'(exp_bc)) begin
      errors++;
      $display("FAIL %s final_regs got src=%h dst=%h bc=%0d exp src=%h dst=%h bc=%0d",
               name, source_address, dest_address, byte_count, exp_src, exp_dst, exp_bc);
    end
    tests++;
    if (dma_error !== 1'b0) begin errors++; $display("FAIL %s dma_error got %b exp 0", name, dma_error); end
  endtask

  task automatic test_aerror();
    int o0, done0, src0, n_rd, n_wr, to;
    o0 = obs.size();
    done0 = n_done;
    src0 = n_inc_src;
    ack_pct = 100;
    err_at = rd_acks + 1;
    err_en = 1'b1;
    start_job(32'h0000_7000, 32'h0000_8000, 2'd0, 2'd0, 2'd1, 16);
    to = 0;
    while (!(master_cbus_req && master_cbus_ack && master_cbus_aerror) && to < 200) begin
      @(negedge cbus_clk);
      to++;
    end
    tests++;
    if (to >= 200) begin errors++; $display("FAIL aerror_seen got none exp one"); end
    @(negedge cbus_clk);
    err_en = 1'b0;
    tests++;
    if (dma_done !== 1'b1 || active !== 1'b1 || master_cbus_req !== 1'b0) begin
      errors++;
      $display("FAIL aerror_err_state got done=%b act=%b req=%b exp 1 1 0", dma_done, active, master_cbus_req);
    end
    @(negedge cbus_clk);
    tests++;
    if (active !== 1'b0 || dma_error !== 1'b1) begin
      errors++;
      $display("FAIL aerror_after got act=%b err=%b exp act=0 err=1", active, dma_error);
    end
    repeat (3) @(negedge cbus_clk);
    n_rd = 0;
    n_wr = 0;
    for (int i = o0; i < obs.size(); i++) begin
      if (obs[i].cmd) n_rd++;
      else n_wr++;
    end
    tests++;
    if (n_rd !== 1 || n_wr !== 0) begin errors++; $display("FAIL aerror_txns got rd=%0d wr=%0d exp rd=1 wr=0", n_rd, n_wr); end
    tests++;
    if (n_done - done0 !== 1) begin errors++; $display("FAIL aerror_done_pulses got %0d exp 1", n_done - done0); end
    tests++;
    if (n_inc_src - src0 !== 1 || byte_count !== 18'd16) begin
      errors++;
      $display("FAIL aerror_strobes got inc_src=%0d bc=%0d exp 1 16", n_inc_src - src0, byte_count);
    end
    tests++;
    if (active !== 1'b0 || dma_error !== 1'b1) begin
      errors++;
      $display("FAIL aerror_sticky got act=%b err=%b exp act=0 err=1", active, dma_error);
    end
  endtask

  task automatic test_reset_mid();
    int to;
    ack_pct = 100;
    start_job(32'h0000_9000, 32'h0000_A000, 2'd0, 2'd0, 2'd1, 32);
    to = 0;
    while (!(master_cbus_req && !master_cbus_cmd) && to < 200) begin
      @(negedge cbus_clk);
      to++;
    end
    tests++;
    if (to >= 200) begin errors++; $display("FAIL rst_mid_no_write got none exp write"); end
    cbus_rst = 1'b1;
    #1;
    tests++;
    if (master_cbus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_same got %b exp 0", master_cbus_req); end
    @(negedge cbus_clk);
    tests++;
    if (master_cbus_req !== 1'b0 || active !== 1'b0 || dma_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got req=%b act=%b done=%b exp 0 0 0", master_cbus_req, active, dma_done);
    end
    cbus_rst = 1'b0;
    @(negedge cbus_clk);
  endtask

  task automatic test_zero_count();
    bit bad;
    bad = 1'b0;
    start_job(32'h0000_B000, 32'h0000_C000, 2'd0, 2'd0, 2'd1, 0);
    repeat (6) begin
      if (active !== 1'b0 || master_cbus_req !== 1'b0) bad = 1'b1;
      @(negedge cbus_clk);
    end
    tests++;
    if (bad) begin errors++; $display("FAIL zero_count got active/req high exp idle"); end
    pend_clr = 1'b1;
    @(negedge cbus_clk);
    pend_clr = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [31:0] s, d;
    for (int i = 0; i < n; i++) begin
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      if (i % 3 == 0) s = 32'hFFFF_FFF0;
      test_transfer($sformatf("rand%0d", i), s, d, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom_range(1, 80), $urandom_range(30, 100), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_transfer("basic", 32'h1000, 32'h2000, 2'd0, 2'd0, 2'd0, 16, 100, 1'b0, 1'b1);
    test_transfer("burst4", 32'h4000, 32'h5000, 2'd0, 2'd0, 2'd1, 40, 100, 1'b0, 1'b1);
    test_transfer("partial", 32'h1100, 32'h2200, 2'd0, 2'd0, 2'd1, 6, 100, 1'b0, 1'b0);
    test_transfer("fixed_dest", 32'h6000, 32'h3000, 2'd0, 2'd1, 2'd1, 12, 100, 1'b0, 1'b0);
    test_aerror();
    test_transfer("after_err", 32'h1200, 32'h2400, 2'd2, 2'd3, 2'd2, 37, 60, 1'b0, 1'b0);
    test_transfer("pending_drop", 32'h1300, 32'h2600, 2'd0, 2'd0, 2'd1, 32, 100, 1'b1, 1'b0);
    test_reset_mid();
    test_transfer("after_rst", 32'h1400, 32'h2800, 2'd0, 2'd0, 2'd2, 20, 100, 1'b0, 1'b0);
    test_zero_count();
    test_random(12);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
